// File: rtl/rf_wb_scheduler_pkg.sv
// Shared constants for the register-file write-back scheduler.
//   DEF_XLEN / DEF_AW : default data and register-address widths
//   ARB_RR / ARB_FIXED : arbitration mode encodings
//   REG_ZERO           : index of the hard-wired zero register
package rf_wb_scheduler_pkg;

   localparam int unsigned DEF_XLEN  = 32;
   localparam int unsigned DEF_AW    = 5;

   localparam int unsigned ARB_RR    = 0;
   localparam int unsigned ARB_FIXED = 1;

   localparam int unsigned REG_ZERO  = 0;

endpackage

// File: rtl/rf_wb_arbiter.sv
// Two-way write-back arbiter with a round-robin priority pointer.
//   clk, rst : clock, asynchronous active-low reset
//   req[1:0] : request per port (bit 0 = ALU, bit 1 = load/store)
//   grant    : one-hot grant, never asserted without the matching request
//   sel      : index of the granted port (valid while |grant)
module rf_wb_arbiter
   import rf_wb_scheduler_pkg::*;
#(
   parameter int unsigned ARB_MODE = ARB_RR
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] grant,
   output logic       sel
);

   // 1 = port 1 wins the next collision (port 0 was granted last)
   logic prio1;

   // Grant selection: single requester always wins, collisions by mode.
   always_comb begin
      grant = 2'b00;
      sel   = 1'b0;
      if (req == 2'b11) begin
         if ((ARB_MODE == ARB_FIXED) || !prio1) begin
            grant = 2'b01;
         end else begin
            grant = 2'b10;
            sel   = 1'b1;
         end
      end else begin
         grant = req;
         sel   = req[1];
      end
   end

   // Pointer moves only when a grant (i.e. a transfer) happens.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prio1 <= 1'b0;
      end else if (|grant) begin
         prio1 <= !sel;
      end
   end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Write-back scheduler and pending-write scoreboard for the register file.
// Arbitrates ALU (port 0) and LSU (port 1) write-backs onto the single
// registered write port, tracks one pending bit per register and reports
// hazards to issue.
//   clk, rst                      : clock, asynchronous active-low reset
//   wbN_valid/ready/rd/data       : write-back handshake per port
//   iss_valid, iss_rd, rs1, rs2   : instruction at issue
//   hz_rs1, hz_rs2, hz_rd         : pending write to the named register
//   rf_wen, rf_rd, rf_wdata       : registered register-file write port
//   busy                          : any pending bit set
//   fwd_rs1, fwd_rs2              : operand may be taken from rf_wdata
// Optional macro RF_WB_FWD_EN enables commit-cycle forwarding.
module rf_wb_scheduler
   import rf_wb_scheduler_pkg::*;
#(
   parameter int unsigned XLEN     = DEF_XLEN,
   parameter int unsigned AW       = DEF_AW,
   parameter int unsigned ARB_MODE = ARB_RR
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wb0_valid,
   output logic            wb0_ready,
   input  logic [AW-1:0]   wb0_rd,
   input  logic [XLEN-1:0] wb0_data,
   input  logic            wb1_valid,
   output logic            wb1_ready,
   input  logic [AW-1:0]   wb1_rd,
   input  logic [XLEN-1:0] wb1_data,
   input  logic            iss_valid,
   input  logic [AW-1:0]   iss_rd,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   output logic            hz_rs1,
   output logic            hz_rs2,
   output logic            hz_rd,
   output logic            rf_wen,
   output logic [AW-1:0]   rf_rd,
   output logic [XLEN-1:0] rf_wdata,
   output logic            busy,
   output logic            fwd_rs1,
   output logic            fwd_rs2
);

   localparam int unsigned NREG = 2 ** AW;
   localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);

   logic [1:0]      grant;
   logic            sel;
   logic            xfer;
   logic [AW-1:0]   wr_rd;
   logic [XLEN-1:0] wr_data;
   logic [NREG-1:0] pending;
   logic [NREG-1:0] pending_nxt;

   rf_wb_arbiter #(
      .ARB_MODE (ARB_MODE)
   ) u_arb (
      .clk   (clk),
      .rst   (rst),
      .req   ({wb1_valid, wb0_valid}),
      .grant (grant),
      .sel   (sel)
   );

   // Ready is held low while reset is asserted, even with valid high.
   assign wb0_ready = grant[0] & rst;
   assign wb1_ready = grant[1] & rst;
   assign xfer      = wb0_ready | wb1_ready;
   assign wr_rd     = sel ? wb1_rd   : wb0_rd;
   assign wr_data   = sel ? wb1_data : wb0_data;

   // Commit register; a transfer to x0 is accepted but never written.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rf_wen   <= 1'b0;
         rf_rd    <= '0;
         rf_wdata <= '0;
      end else begin
         rf_wen <= xfer && (wr_rd != ZERO);
         if (xfer) begin
            rf_rd    <= wr_rd;
            rf_wdata <= wr_data;
         end
      end
   end

   // Scoreboard update: clear on commit, then set on issue so set wins.
   always_comb begin
      pending_nxt = pending;
      if (rf_wen) begin
         pending_nxt[rf_rd] = 1'b0;
      end
      if (iss_valid && (iss_rd != ZERO)) begin
         pending_nxt[iss_rd] = 1'b1;
      end
      pending_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending <= '0;
      end else begin
         pending <= pending_nxt;
      end
   end

`ifdef RF_WB_FWD_EN
   // The committing value is on rf_wdata this cycle, so issue can use it.
   assign fwd_rs1 = rf_wen && (rf_rd == rs1) && (rs1 != ZERO);
   assign fwd_rs2 = rf_wen && (rf_rd == rs2) && (rs2 != ZERO);
`else
   assign fwd_rs1 = 1'b0;
   assign fwd_rs2 = 1'b0;
`endif

   assign hz_rs1 = pending[rs1] && (rs1 != ZERO) && !fwd_rs1;
   assign hz_rs2 = pending[rs2] && (rs2 != ZERO) && !fwd_rs2;
   assign hz_rd  = pending[iss_rd] && (iss_rd != ZERO);
   assign busy   = |pending[NREG-1:1];

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed self-checking bench for rf_wb_scheduler: one round-robin
// instance (dut) and one fixed-priority instance (dut_fx) on shared inputs.
module tb_rf_wb_scheduler;

`ifdef RF_WB_FWD_EN
   localparam logic FWD = 1'b1;
`else
   localparam logic FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        wb0_valid, wb1_valid, iss_valid;
   logic [4:0]  wb0_rd, wb1_rd, iss_rd, rs1, rs2;
   logic [31:0] wb0_data, wb1_data;

   logic        wb0_ready, wb1_ready, hz_rs1, hz_rs2, hz_rd, rf_wen, busy;
   logic        fwd_rs1, fwd_rs2;
   logic [4:0]  rf_rd;
   logic [31:0] rf_wdata;

   logic        f_wb0_ready, f_wb1_ready, f_hz_rs1, f_hz_rs2, f_hz_rd;
   logic        f_rf_wen, f_busy, f_fwd_rs1, f_fwd_rs2;
   logic [4:0]  f_rf_rd;
   logic [31:0] f_rf_wdata;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   rf_wb_scheduler #(.ARB_MODE(0)) dut (
      .clk(clk), .rst(rst),
      .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_rd(wb0_rd), .wb0_data(wb0_data),
      .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_rd(wb1_rd), .wb1_data(wb1_data),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2),
      .hz_rs1(hz_rs1), .hz_rs2(hz_rs2), .hz_rd(hz_rd),
      .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .busy(busy),
      .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2)
   );

   rf_wb_scheduler #(.ARB_MODE(1)) dut_fx (
      .clk(clk), .rst(rst),
      .wb0_valid(wb0_valid), .wb0_ready(f_wb0_ready), .wb0_rd(wb0_rd), .wb0_data(wb0_data),
      .wb1_valid(wb1_valid), .wb1_ready(f_wb1_ready), .wb1_rd(wb1_rd), .wb1_data(wb1_data),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2),
      .hz_rs1(f_hz_rs1), .hz_rs2(f_hz_rs2), .hz_rd(f_hz_rd),
      .rf_wen(f_rf_wen), .rf_rd(f_rf_rd), .rf_wdata(f_rf_wdata), .busy(f_busy),
      .fwd_rs1(f_fwd_rs1), .fwd_rs2(f_fwd_rs2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_cmp++;
      assert (obs === want) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      wb0_valid = 1'b1; wb0_rd = 5'd3; wb0_data = 32'h0;
      wb1_valid = 1'b0; wb1_rd = 5'd0; wb1_data = 32'h0;
      iss_valid = 1'b0; iss_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;

      // Reset state, with wb0_valid held high
      #12;
      chk("rst_rf_wen", {31'b0, rf_wen}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_hz_rd", {31'b0, hz_rd}, 32'd0);
      chk("rst_ready", {31'b0, wb0_ready}, 32'd0);
      chk("rst_rf_wdata", rf_wdata, 32'd0);
      wb0_valid = 1'b0;
      rst = 1'b1;

      // Issue x5, then write it back from port 0
      tick();
      iss_valid = 1'b1; iss_rd = 5'd5; rs1 = 5'd5;
      #1;
      chk("x5_hz_rs1_pre", {31'b0, hz_rs1}, 32'd0);
      tick();
      iss_valid = 1'b0;
      wb0_valid = 1'b1; wb0_rd = 5'd5; wb0_data = 32'hDEADBEEF;
      #1;
      chk("x5_hz_rs1", {31'b0, hz_rs1}, 32'd1);
      chk("x5_busy", {31'b0, busy}, 32'd1);
      chk("x5_wb0_ready", {31'b0, wb0_ready}, 32'd1);
      chk("x5_wb1_ready", {31'b0, wb1_ready}, 32'd0);
      chk("x5_rf_wen_pre", {31'b0, rf_wen}, 32'd0);
      tick();
      wb0_valid = 1'b0;
      #1;
      chk("x5_rf_wen", {31'b0, rf_wen}, 32'd1);
      chk("x5_rf_rd", {27'b0, rf_rd}, 32'd5);
      chk("x5_rf_wdata", rf_wdata, 32'hDEADBEEF);
      chk("x5_hz_rs1_commit", {31'b0, hz_rs1}, {31'b0, !FWD});
      chk("x5_fwd_rs1", {31'b0, fwd_rs1}, {31'b0, FWD});
      tick();
      chk("x5_rf_wen_drop", {31'b0, rf_wen}, 32'd0);
      chk("x5_hz_rs1_post", {31'b0, hz_rs1}, 32'd0);
      chk("x5_busy_post", {31'b0, busy}, 32'd0);

      // Port 1 write-back to x0 while x20 becomes pending
      iss_valid = 1'b1; iss_rd = 5'd20;
      wb1_valid = 1'b1; wb1_rd = 5'd0; wb1_data = 32'h1234;
      #1;
      chk("x0_wb1_ready", {31'b0, wb1_ready}, 32'd1);
      chk("x0_wb0_ready", {31'b0, wb0_ready}, 32'd0);
      tick();
      iss_valid = 1'b0; wb1_valid = 1'b0;
      #1;
      chk("x0_rf_wen", {31'b0, rf_wen}, 32'd0);
      chk("x0_busy", {31'b0, busy}, 32'd1);
      chk("x20_hz_rd", {31'b0, hz_rd}, 32'd1);

      // Both ports requesting for 4 cycles
      wb0_valid = 1'b1; wb0_rd = 5'd1;  wb0_data = 32'hA1;
      wb1_valid = 1'b1; wb1_rd = 5'd11; wb1_data = 32'hB11;
      for (int c = 0; c < 4; c++) begin
         #1;
         chk("rr_wb0_ready", {31'b0, wb0_ready}, (c % 2 == 0) ? 32'd1 : 32'd0);
         chk("rr_wb1_ready", {31'b0, wb1_ready}, (c % 2 == 1) ? 32'd1 : 32'd0);
         chk("fx_wb0_ready", {31'b0, f_wb0_ready}, 32'd1);
         chk("fx_wb1_ready", {31'b0, f_wb1_ready}, 32'd0);
         tick();
         chk("rr_rf_wen", {31'b0, rf_wen}, 32'd1);
         if (c % 2 == 0) begin
            chk("rr_rf_rd0", {27'b0, rf_rd}, 32'(1 + c / 2));
            wb0_rd = wb0_rd + 5'd1; wb0_data = wb0_data + 32'd1;
         end else begin
            chk("rr_rf_rd1", {27'b0, rf_rd}, 32'(11 + c / 2));
            chk("rr_rf_wdata1", rf_wdata, 32'(32'hB11 + c / 2));
            wb1_rd = wb1_rd + 5'd1; wb1_data = wb1_data + 32'd1;
         end
      end
      wb0_valid = 1'b0; wb1_valid = 1'b0;
      tick();
      chk("rr_rf_wen_drop", {31'b0, rf_wen}, 32'd0);

      // Re-issue x7 on the edge that commits x7: set wins
      iss_valid = 1'b1; iss_rd = 5'd7;
      tick();
      iss_valid = 1'b0;
      wb0_valid = 1'b1; wb0_rd = 5'd7; wb0_data = 32'h77;
      tick();
      wb0_valid = 1'b0;
      iss_valid = 1'b1; iss_rd = 5'd7;
      #1;
      chk("x7_rf_wen", {31'b0, rf_wen}, 32'd1);
      chk("x7_hz_rd_commit", {31'b0, hz_rd}, 32'd1);
      tick();
      iss_valid = 1'b0;
      #1;
      chk("x7_hz_rd_kept", {31'b0, hz_rd}, 32'd1);

      // rs2 = x9 during its commit cycle
      iss_valid = 1'b1; iss_rd = 5'd9;
      tick();
      iss_valid = 1'b0;
      wb1_valid = 1'b1; wb1_rd = 5'd9; wb1_data = 32'h99; rs2 = 5'd9;
      #1;
      chk("x9_hz_rs2_pre", {31'b0, hz_rs2}, 32'd1);
      chk("x9_wb1_ready", {31'b0, wb1_ready}, 32'd1);
      tick();
      wb1_valid = 1'b0;
      #1;
      chk("x9_rf_wdata", rf_wdata, 32'h99);
      chk("x9_hz_rs2", {31'b0, hz_rs2}, {31'b0, !FWD});
      chk("x9_fwd_rs2", {31'b0, fwd_rs2}, {31'b0, FWD});
      tick();
      chk("x9_hz_rs2_post", {31'b0, hz_rs2}, 32'd0);

      // Reset mid-flight: x20, x7, x3 pending and a write registered
      wb0_valid = 1'b1; wb0_rd = 5'd25; wb0_data = 32'h25;
      iss_valid = 1'b1; iss_rd = 5'd3; rs1 = 5'd7;
      tick();
      iss_valid = 1'b0;
      #1;
      chk("pre_rst_rf_wen", {31'b0, rf_wen}, 32'd1);
      chk("pre_rst_hz_rs1", {31'b0, hz_rs1}, 32'd1);
      rst = 1'b0;
      #1;
      chk("mid_rst_rf_wen", {31'b0, rf_wen}, 32'd0);
      chk("mid_rst_rf_rd", {27'b0, rf_rd}, 32'd0);
      chk("mid_rst_rf_wdata", rf_wdata, 32'd0);
      chk("mid_rst_busy", {31'b0, busy}, 32'd0);
      chk("mid_rst_hz_rs1", {31'b0, hz_rs1}, 32'd0);
      chk("mid_rst_ready", {31'b0, wb0_ready}, 32'd0);
      tick();
      chk("rst_hold_rf_wen", {31'b0, rf_wen}, 32'd0);
      wb0_valid = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
